wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone classic slave port between NUM_MASTERS wb_master-style requesters.
- Ownership is per bus cycle: a master holds the bus from grant until it drops cyc.
- A watchdog terminates cycles the slave never acknowledges.
- Sits between the master cluster and the shared slave/interconnect.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- TIMEOUT, 256, cycles a strobed transfer may wait for ack before abort. 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- m_cyc_i  in  NUM_MASTERS  per-master cycle request
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  flattened addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  flattened write data
- m_ack_o  out  NUM_MASTERS  per-master ack
- m_err_o  out  NUM_MASTERS  per-master timeout error pulse
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_adr_o  out  ADDR_WIDTH  slave address
- s_dat_o  out  DATA_WIDTH  slave write data
- s_ack_i  in  1  slave ack
- s_dat_i  in  DATA_WIDTH  slave read data
- grant_o  out  NUM_MASTERS  one-hot current owner, 0 when idle
- busy_o  out  1  bus owned

Behaviour:
- Reset (rst=0, async): state=IDLE, grant_o=0, last_grant=NUM_MASTERS-1 so master 0 has first priority, timeout counter=0.
- Reset values of outputs: every s_* output is 0, m_ack_o=0, m_err_o=0, busy_o=0.
- State IDLE:
  - All s_* outputs are 0.
  - If any m_cyc_i is high, pick the first requester searching from last_grant+1 upward with wrap.
  - Register the winner into grant_o and last_grant, then go to GRANT. Arbitration latency is 1 cycle from cyc request to s_cyc_o.
- State GRANT (owner g):
  - s_cyc/stb/we/adr/dat are driven combinationally from master g.
  - m_ack_o[g] = s_ack_i & m_stb_i[g]; all other acks are 0.
  - m_dat_o = s_dat_i at all times.
  - When m_cyc_i[g]=0, go to IDLE with grant_o=0 next cycle. s_cyc_o follows m_cyc_i[g] combinationally, so it drops the same cycle.
  - A minimum of one IDLE cycle separates successive owners; there is no back-to-back handover.
- Watchdog (TIMEOUT>0):
  - The counter increments each GRANT cycle with m_stb_i[g]=1 and s_ack_i=0.
  - It clears on ack, on stb low, and on leaving GRANT.
  - When the counter reaches TIMEOUT-1 with still no ack, go to ABORT.
- State ABORT:
  - s_cyc_o=s_stb_o=0.
  - m_err_o[g]=1 for exactly the first ABORT cycle; m_ack_o=0.
  - Remain in ABORT until m_cyc_i[g]=0, then go to IDLE.
  - last_grant is unchanged, so the faulty master loses priority next round.
- Simultaneous events:
  - s_ack_i in the same cycle the counter hits TIMEOUT-1 means the ack wins; no abort.
  - m_cyc_i[g] dropping while ack is pending means release wins; the ack is discarded because m_ack_o is gated by m_stb_i[g].
- Fairness: with all masters continuously requesting, grants rotate 0,1,...,N-1,0. No master waits more than NUM_MASTERS-1 ownership periods.
- Requests from non-owners are ignored (not latched) until IDLE.
- Reset mid-transfer: all outputs return to their reset values immediately and asynchronously, and the in-flight cycle is lost.
- busy_o = (state != IDLE).

Decomposition:
- Package wb_arb_pkg holds:
  - state encoding IDLE=2'd0, GRANT=2'd1, ABORT=2'd2;
  - function clog2 for grant index and counter widths;
  - the timeout counter width, derived as clog2(TIMEOUT+1).
- Sub-module rr_pick:
  - purely combinational;
  - inputs req vector and last index;
  - outputs one-hot winner, winner index and valid.
  - It is reused by future interconnect blocks.
- The top module holds the FSM, counter and muxes.

Test Plan:
- Single master 1 raises cyc with write adr=5, dat=32'h55555555; slave acks after 2 cycles:
  - s_cyc_o rises 1 cycle after m_cyc_i;
  - m_ack_o=2'b10 on the ack cycle;
  - grant_o returns to 0 one cycle after cyc drops.
- Both masters request in the same cycle from reset: grant order is 0, 1, 0, 1 over four transactions, with exactly one IDLE cycle between owners.
- Master 0 owns the bus and master 1 requests mid-cycle:
  - s_adr_o and s_dat_o never show master 1 values until master 0 drops cyc;
  - m_ack_o[1] stays 0 throughout.
- Read by master 0 with slave returning 32'hAAAAAAAA: m_dat_o=32'hAAAAAAAA on the ack cycle, and m_ack_o[0] is a 1-cycle pulse.
- TIMEOUT=8 and slave never acks:
  - m_err_o[0] pulses once after 8 strobed cycles;
  - s_cyc_o=0 in ABORT;
  - arbiter reaches IDLE after master 0 drops cyc;
  - master 1 is granted next.
- rst asserted mid-transfer while granted:
  - all outputs go to 0 asynchronously;
  - after release, master 0 has priority again.

Source files
------------

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and width helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned rem;
        int unsigned width;
        width = 0;
        rem   = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            rem   = rem >> 1;
            width = width + 1;
        end
        return width;
    endfunction

    // Width of a grant index for n requesters (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    // Width of the watchdog counter, clog2(timeout+1), at least one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout > 0) ? clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above 'last', with wrap.
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Offsets are scanned farthest-first so the nearest requester after 'last' is the final writer.
    always_comb begin
        int            pos;
        logic [IW-1:0] sel;
        onehot = '0;
        idx    = '0;
        valid  = |req;
        for (int off = int'(N); off >= 1; off--) begin
            pos = int'(last) + off;
            if (pos >= int'(N)) begin
                pos = pos - int'(N);
            end
            sel = IW'(pos);
            if (req[sel]) begin
                onehot      = '0;
                onehot[sel] = 1'b1;
                idx         = sel;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave among NUM_MASTERS masters,
// with a watchdog that aborts transfers the slave never acknowledges.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned TIMEOUT     = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    input  logic                              s_ack_i,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    output logic [NUM_MASTERS-1:0]            grant_o,
    output logic                              busy_o
);

    localparam int unsigned   IW       = idx_width(NUM_MASTERS);
    localparam int unsigned   CW       = cnt_width(TIMEOUT);
    localparam bit            WD_EN    = (TIMEOUT > 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

    arb_state_e             state;
    arb_state_e             state_nxt;
    logic [IW-1:0]          last_grant;
    logic [CW-1:0]          wd_cnt;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;
    logic                   own_cyc;
    logic                   own_stb;
    logic                   timeout_hit;

    rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_pick (
        .req    (m_cyc_i),
        .last   (last_grant),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // grant_o is one-hot for the owner, so masking selects the owner's request lines.
    assign own_cyc     = |(m_cyc_i & grant_o);
    assign own_stb     = |(m_stb_i & grant_o);
    assign timeout_hit = WD_EN && own_stb && !s_ack_i && (wd_cnt == CNT_LAST);
    assign m_dat_o     = s_dat_i;
    assign busy_o      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: release beats timeout, ack beats timeout (folded into timeout_hit).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!own_cyc) begin
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    state_nxt = ABORT;
                end
            end
            ABORT: begin
                if (!own_cyc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ownership, watchdog counter and the one-cycle error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_o    <= '0;
            last_grant <= LAST_RST;
            wd_cnt     <= '0;
            m_err_o    <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                grant_o    <= pick_onehot;
                last_grant <= pick_idx;
            end else if (state_nxt == IDLE) begin
                grant_o <= '0;
            end
            if (WD_EN && state == GRANT && state_nxt == GRANT && own_stb && !s_ack_i) begin
                wd_cnt <= wd_cnt + CW'(1);
            end else begin
                wd_cnt <= '0;
            end
            m_err_o <= (state == GRANT && state_nxt == ABORT) ? grant_o : '0;
        end
    end

    // Slave-side mux from the owner and owner-only ack, live only while granted.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        if (state == GRANT) begin
            s_cyc_o = own_cyc;
            s_stb_o = own_stb;
            s_we_o  = |(m_we_i & grant_o);
            for (int k = 0; k < int'(NUM_MASTERS); k++) begin
                if (grant_o[k]) begin
                    s_adr_o = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                    s_dat_o = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            m_ack_o = grant_o & m_stb_i & {NUM_MASTERS{s_ack_i}};
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed vector table, corner sequences,
// and randomized traffic against a behavioural ownership model.
module tb_wb_rr_arbiter;

    localparam int NM = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_0005;
    localparam logic [31:0] D0 = 32'hC0DE_0000;
    localparam logic [31:0] D1 = 32'h5555_5555;
    localparam logic [31:0] RD = 32'hAAAA_AAAA;

    logic              clk = 1'b0;
    logic              rst;
    logic              cyc_a [NM];
    logic              stb_a [NM];
    logic              we_a  [NM];
    logic [AW-1:0]     adr_a [NM];
    logic [DW-1:0]     dat_a [NM];
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM-1:0]     m_ack, m_err, grant;
    logic [DW-1:0]     m_dat_o;
    logic              s_cyc, s_stb, s_we, s_ack, busy;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_o, s_dat_i;

    int total = 0;
    int bad   = 0;

    assign m_cyc = {cyc_a[1], cyc_a[0]};
    assign m_stb = {stb_a[1], stb_a[0]};
    assign m_we  = {we_a[1],  we_a[0]};
    assign m_adr = {adr_a[1], adr_a[0]};
    assign m_dat = {dat_a[1], dat_a[0]};

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .NUM_MASTERS (NM),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .TIMEOUT     (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_ack_o (m_ack),
        .m_err_o (m_err),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc),
        .s_stb_o (s_stb),
        .s_we_o  (s_we),
        .s_adr_o (s_adr),
        .s_dat_o (s_dat_o),
        .s_ack_i (s_ack),
        .s_dat_i (s_dat_i),
        .grant_o (grant),
        .busy_o  (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] cyc, input logic [1:0] stb, input logic [1:0] we, input logic ack);
        for (int k = 0; k < NM; k++) begin
            cyc_a[k] = cyc[k];
            stb_a[k] = stb[k];
            we_a[k]  = we[k];
        end
        s_ack = ack;
    endtask

    typedef struct {
        logic [1:0]  cyc, stb, we;
        logic        ack;
        logic [1:0]  grant;
        logic        scyc, sstb, swe;
        logic [31:0] adr;
        logic [1:0]  mack;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] cyc, input logic [1:0] stb, input logic [1:0] we,
                                input logic ack, input logic [1:0] g, input logic scyc, input logic sstb,
                                input logic swe, input logic [31:0] adr, input logic [1:0] mack,
                                input logic bsy);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack;
        v.grant = g; v.scyc = scyc; v.sstb = sstb; v.swe = swe;
        v.adr = adr; v.mack = mack; v.busy = bsy;
        return v;
    endfunction

    function automatic logic [31:0] owner_dat(input logic [1:0] g);
        if (g == 2'b01) return D0;
        if (g == 2'b10) return D1;
        return 32'h0;
    endfunction

    // Reference model: who owns the bus, who owned it last, how long the owner's
    // strobe has gone unanswered, and whether its cycle was aborted.
    int own, last, waitc;
    bit abrt, errp;

    task automatic model_reset();
        own = -1; last = NM - 1; waitc = 0; abrt = 0; errp = 0;
    endtask

    task automatic model_step();
        int c;
        errp = 0;
        if (own < 0) begin
            for (int d = 1; d <= NM; d++) begin
                c = (last + d) % NM;
                if (cyc_a[c] && own < 0) begin
                    own = c; last = c; waitc = 0;
                end
            end
        end else if (!cyc_a[own]) begin
            own = -1; abrt = 0; waitc = 0;
        end else if (!abrt) begin
            if (stb_a[own] && !s_ack) begin
                waitc++;
                if (waitc == TO) begin
                    abrt = 1; errp = 1; waitc = 0;
                end
            end else begin
                waitc = 0;
            end
        end
    endtask

    task automatic model_check();
        logic [1:0]  eg, eack;
        logic        ecyc, estb, ewe;
        logic [31:0] eadr, edat;
        eg = (own < 0) ? 2'b00 : 2'(1 << own);
        ecyc = 0; estb = 0; ewe = 0; eadr = 0; edat = 0; eack = 0;
        if (own >= 0 && !abrt) begin
            ecyc = cyc_a[own]; estb = stb_a[own]; ewe = we_a[own];
            eadr = adr_a[own]; edat = dat_a[own];
            eack = (s_ack && stb_a[own]) ? eg : 2'b00;
        end
        chk("rnd_grant", 32'(grant), 32'(eg));
        chk("rnd_s_cyc", 32'(s_cyc), 32'(ecyc));
        chk("rnd_s_stb", 32'(s_stb), 32'(estb));
        chk("rnd_s_we", 32'(s_we), 32'(ewe));
        chk("rnd_s_adr", s_adr, eadr);
        chk("rnd_s_dat", s_dat_o, edat);
        chk("rnd_m_ack", 32'(m_ack), 32'(eack));
        chk("rnd_m_err", 32'(m_err), 32'(errp ? eg : 2'b00));
        chk("rnd_busy", 32'(busy), 32'(own >= 0));
        chk("rnd_m_dat", m_dat_o, s_dat_i);
    endtask

    initial begin
        logic [1:0] eg;
        bit         dead;
        rst = 1'b0;
        drive(2'b11, 2'b11, 2'b11, 1'b1);
        adr_a[0] = A0; adr_a[1] = A1; dat_a[0] = D0; dat_a[1] = D1;
        s_dat_i = RD;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc), 32'h0);
        chk("rst_s_stb", 32'(s_stb), 32'h0);
        chk("rst_m_ack", 32'(m_ack), 32'h0);
        chk("rst_m_err", 32'(m_err), 32'h0);
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        rst = 1'b1;

        // Single master 1 write, then two masters alternating 0,1,0,1.
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 32'h0, 2'b00, 0));
        tbl.push_back(mk(2'b10, 2'b10, 2'b10, 0, 2'b00, 0, 0, 0, 32'h0, 2'b00, 0));
        tbl.push_back(mk(2'b10, 2'b10, 2'b10, 0, 2'b10, 1, 1, 1, A1,    2'b00, 1));
        tbl.push_back(mk(2'b10, 2'b00, 2'b10, 1, 2'b10, 1, 0, 1, A1,    2'b00, 1));
        tbl.push_back(mk(2'b10, 2'b10, 2'b10, 1, 2'b10, 1, 1, 1, A1,    2'b10, 1));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0, 2'b10, 0, 0, 0, A1,    2'b00, 1));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 32'h0, 2'b00, 0));
        tbl.push_back(mk(2'b11, 2'b11, 2'b10, 0, 2'b00, 0, 0, 0, 32'h0, 2'b00, 0));
        tbl.push_back(mk(2'b11, 2'b11, 2'b10, 0, 2'b01, 1, 1, 0, A0,    2'b00, 1));
        tbl.push_back(mk(2'b11, 2'b11, 2'b10, 1, 2'b01, 1, 1, 0, A0,    2'b01, 1));
        tbl.push_back(mk(2'b10, 2'b10, 2'b10, 0, 2'b01, 0, 0, 0, A0,    2'b00, 1));
        tbl.push_back(mk(2'b10, 2'b10, 2'b10, 0, 2'b00, 0, 0, 0, 32'h0, 2'b00, 0));
        tbl.push_back(mk(2'b11, 2'b11, 2'b10, 1, 2'b10, 1, 1, 1, A1,    2'b10, 1));
        tbl.push_back(mk(2'b01, 2'b01, 2'b00, 0, 2'b10, 0, 0, 0, A1,    2'b00, 1));
        tbl.push_back(mk(2'b01, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0, 32'h0, 2'b00, 0));
        tbl.push_back(mk(2'b11, 2'b11, 2'b10, 1, 2'b01, 1, 1, 0, A0,    2'b01, 1));
        tbl.push_back(mk(2'b10, 2'b10, 2'b10, 0, 2'b01, 0, 0, 0, A0,    2'b00, 1));
        tbl.push_back(mk(2'b10, 2'b10, 2'b10, 0, 2'b00, 0, 0, 0, 32'h0, 2'b00, 0));
        tbl.push_back(mk(2'b10, 2'b10, 2'b10, 1, 2'b10, 1, 1, 1, A1,    2'b10, 1));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0, 2'b10, 0, 0, 0, A1,    2'b00, 1));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 32'h0, 2'b00, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].ack);
            @(negedge clk);
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
            chk($sformatf("vec%0d_s_cyc", i), 32'(s_cyc), 32'(tbl[i].scyc));
            chk($sformatf("vec%0d_s_stb", i), 32'(s_stb), 32'(tbl[i].sstb));
            chk($sformatf("vec%0d_s_we", i), 32'(s_we), 32'(tbl[i].swe));
            chk($sformatf("vec%0d_s_adr", i), s_adr, tbl[i].adr);
            chk($sformatf("vec%0d_s_dat", i), s_dat_o, owner_dat(tbl[i].grant));
            chk($sformatf("vec%0d_m_ack", i), 32'(m_ack), 32'(tbl[i].mack));
            chk($sformatf("vec%0d_m_err", i), 32'(m_err), 32'h0);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            @(posedge clk);
            #1;
        end

        // Watchdog: master 0 strobes with no ack, is aborted, then master 1 wins next.
        for (int k = 0; k < 14; k++) begin
            if (k <= 9)       drive(2'b01, 2'b01, 2'b00, 1'b0);
            else if (k == 10) drive(2'b11, 2'b11, 2'b00, 1'b0);
            else              drive(2'b10, 2'b10, 2'b00, 1'b0);
            @(negedge clk);
            eg = (k == 0 || k == 12) ? 2'b00 : ((k == 13) ? 2'b10 : 2'b01);
            chk($sformatf("wd%0d_grant", k), 32'(grant), 32'(eg));
            chk($sformatf("wd%0d_s_cyc", k), 32'(s_cyc), 32'((k >= 1 && k <= 8) || k == 13));
            chk($sformatf("wd%0d_s_stb", k), 32'(s_stb), 32'((k >= 1 && k <= 8) || k == 13));
            chk($sformatf("wd%0d_m_err", k), 32'(m_err), (k == 9) ? 32'h1 : 32'h0);
            chk($sformatf("wd%0d_m_ack", k), 32'(m_ack), 32'h0);
            chk($sformatf("wd%0d_busy", k), 32'(busy), 32'(!(k == 0 || k == 12)));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while master 1 is granted and the slave is acking.
        drive(2'b10, 2'b10, 2'b10, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_s_cyc", 32'(s_cyc), 32'h0);
        chk("arst_s_stb", 32'(s_stb), 32'h0);
        chk("arst_s_adr", s_adr, 32'h0);
        chk("arst_m_ack", 32'(m_ack), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(2'b11, 2'b11, 2'b00, 1'b0);
        @(negedge clk);
        chk("post_rst_idle_grant", 32'(grant), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_grant", 32'(grant), 32'h1);
        chk("post_rst_s_adr", s_adr, A0);
        @(posedge clk);
        #1;
        // Read by master 0: ack is a single-cycle pulse carrying slave data.
        s_ack = 1'b1;
        @(negedge clk);
        chk("read_m_ack", 32'(m_ack), 32'h1);
        chk("read_m_dat", m_dat_o, RD);
        chk("read_s_we", 32'(s_we), 32'h0);
        @(posedge clk);
        #1;
        s_ack = 1'b0;
        @(negedge clk);
        chk("read_ack_end", 32'(m_ack), 32'h0);
        chk("read_grant_hold", 32'(grant), 32'h1);
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model.
        rst = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        dead = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) dead = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NM; k++) begin
                if (cyc_a[k]) begin
                    if ($urandom_range(0, 9) == 0) cyc_a[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    cyc_a[k] = 1'b1;
                end
                stb_a[k] = cyc_a[k] && ($urandom_range(0, 7) != 0);
                we_a[k]  = 1'($urandom);
                adr_a[k] = $urandom;
                dat_a[k] = $urandom;
            end
            s_ack   = !dead && ($urandom_range(0, 2) == 0);
            s_dat_i = $urandom;
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_step();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
